// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Imported by the converter top and its digit-adjust cell.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bcd_state_t;

    // ceil(bin_w * log10(2)), using log10(2) ~= 0.30103
    function automatic int min_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
// Purely combinational; the carry out of the 4-bit add is dropped.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    output bcd_digit_t y
);

    always_comb begin
        y = a;
        if (a >= 4'd5) begin
            y = a + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Binary to BCD converter, one double-dabble step per clock.
// Results and leading-zero flags are held until the next completion.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIGITS-1:0]     blank_o
);

    localparam int BW = 4 * DIGITS;
    localparam int TW = BW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS too small for BIN_W");
    end

    bcd_state_t       state;
    logic [TW-1:0]    work;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    adj;
    logic [TW-1:0]    work_nxt;
    logic [BW-1:0]    bcd_nxt;
    logic [DIGITS-1:0] blank_nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .a (work[BIN_W + 4*g +: 4]),
            .y (adj[4*g +: 4])
        );
    end

    assign work_nxt = {adj, work[BIN_W-1:0]} << 1;
    assign bcd_nxt  = work_nxt[TW-1 -: BW];

    // A digit is blank when it and every more significant digit is zero
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_nxt  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above   = zero_above && (bcd_nxt[4*k +: 4] == 4'd0);
            blank_nxt[k] = zero_above && (k != 0);
        end
    end

    assign busy_o = (state == SHIFT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            work    <= '0;
            cnt     <= '0;
            valid_o <= 1'b0;
            bcd_o   <= '0;
            blank_o <= BLANK_RST;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        work  <= {{BW{1'b0}}, bin_i};
                        cnt   <= CW'(BIN_W);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= work_nxt;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state   <= IDLE;
                        bcd_o   <= bcd_nxt;
                        blank_o <= blank_nxt;
                        valid_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, random values
// against a decimal reference model, and multi-cycle corner cases.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin = '0;
    logic        busy;
    logic        valid;
    logic [19:0] bcd;
    logic [4:0]  blank;

    int n_checks = 0;
    int n_fails  = 0;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy),
        .valid_o (valid),
        .bcd_o   (bcd),
        .blank_o (blank)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic [4:0]  blank;
    } vec_t;

    function automatic logic [19:0] model_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_blank(input int v);
        logic [4:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 1; k < 5; k++) begin
            p = p * 10;
            r[k] = (v < p);
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Start one conversion and check latency, result and pulse width
    task automatic convert(input logic [15:0] v, input logic [19:0] exp_bcd,
                           input logic [4:0] exp_blank, input string nm);
        int busy_cnt;
        bit got;
        busy_cnt = 0;
        got = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (valid) begin
                got = 1;
            end else begin
                if (busy) busy_cnt++;
                @(negedge clk);
            end
        end
        check({nm, " valid seen"}, 32'(got), 32'd1);
        check({nm, " busy cycles"}, 32'(busy_cnt), 32'd16);
        check({nm, " bcd"}, 32'(bcd), 32'(exp_bcd));
        check({nm, " blank"}, 32'(blank), 32'(exp_blank));
        @(negedge clk);
        check({nm, " valid width"}, 32'(valid), 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        int   nvalid;
        int   cyc;
        logic [19:0] first_bcd;
        logic [15:0] r;

        vecs.push_back('{16'd0,     20'h00000, 5'b11110});
        vecs.push_back('{16'd65535, 20'h65535, 5'b00000});
        vecs.push_back('{16'd1234,  20'h01234, 5'b10000});
        vecs.push_back('{16'd7,     20'h00007, 5'b11110});
        vecs.push_back('{16'd10,    20'h00010, 5'b11100});
        vecs.push_back('{16'd100,   20'h00100, 5'b11000});
        vecs.push_back('{16'd9999,  20'h09999, 5'b10000});
        vecs.push_back('{16'd10000, 20'h10000, 5'b00000});
        vecs.push_back('{16'd59999, 20'h59999, 5'b00000});

        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(valid), 32'd0);
        check("reset bcd", 32'(bcd), 32'd0);
        check("reset blank", 32'(blank), 32'b11110);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            convert(vecs[i].bin, vecs[i].bcd, vecs[i].blank,
                    $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            r = (i % 3 == 0) ? 16'($urandom_range(0, 99))
                             : 16'($urandom_range(0, 65535));
            convert(r, model_bcd(int'(r)), model_blank(int'(r)),
                    $sformatf("rand%0d_%0d", i, r));
        end

        // Start while busy is ignored
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd500;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        bin   = 16'd999;
        @(negedge clk);
        start = 1'b0;
        nvalid = 0;
        first_bcd = '0;
        for (int i = 0; i < 60; i++) begin
            if (valid) begin
                if (nvalid == 0) first_bcd = bcd;
                nvalid++;
            end
            @(negedge clk);
        end
        check("busy-start valid count", 32'(nvalid), 32'd1);
        check("busy-start bcd", 32'(first_bcd), 32'h00500);

        // Back-to-back: restart in the valid cycle
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd42;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b first valid", 32'(valid), 32'd1);
        check("b2b first bcd", 32'(bcd), 32'h00042);
        start = 1'b1;
        bin   = 16'd43;
        cyc = 0;
        do begin
            @(negedge clk);
            if (cyc == 0) begin
                start = 1'b0;
                check("b2b accepted busy", 32'(busy), 32'd1);
            end
            cyc++;
        end while (!valid && cyc < 40);
        check("b2b spacing", 32'(cyc), 32'd17);
        check("b2b second bcd", 32'(bcd), 32'h00043);
        check("b2b second blank", 32'(blank), 32'b11100);
        @(negedge clk);

        // Asynchronous reset mid-conversion
        start = 1'b1;
        bin   = 16'd9999;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset valid", 32'(valid), 32'd0);
        check("async reset bcd", 32'(bcd), 32'd0);
        check("async reset blank", 32'(blank), 32'b11110);
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid || busy) nvalid++;
        end
        check("post-reset idle", 32'(nvalid), 32'd0);
        convert(16'd10, 20'h00010, 5'b11100, "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
